cmplx_mult_pipe: RTL and testbench

Pipelined, parametrised fixed-point complex multiplier for the OFDM datapath, used for twiddle rotation, channel equalisation and pilot de-rotation. It multiplies a stream of A samples by B samples, with an optional per-sample conjugate of B. Results are rescaled with round-half-up, then saturated to the output width. A valid/ready handshake with full backpressure lets it sit between the FFT and the equaliser FIFOs.

---
 rtl/cmplx_pkg.sv | 21 ++
 rtl/cmplx_mult_pipe_if.sv | 31 +++
 rtl/cmplx_round_sat.sv | 50 +++++
 rtl/cmplx_mult_pipe.sv | 146 ++++++++++++++
 tb/tb_cmplx_mult_pipe.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmplx_pkg.sv
// Shared types and constants for the complex multiplier datapath and its users.
// Pipeline latency is exported so alignment logic downstream can match it.
package cmplx_pkg;

    localparam int CMPLX_W      = 16;
    localparam int PIPE_LATENCY = 3;

    typedef struct packed {
        logic signed [CMPLX_W-1:0] re;
        logic signed [CMPLX_W-1:0] im;
    } cmplx_t;

    // Half an output LSB, expressed at product scale; zero when there are no fractional bits.
    function automatic logic [63:0] rnd_offset(input int frac);
        if (frac <= 0) begin
            return 64'd0;
        end
        return 64'd1 << (frac - 1);
    endfunction

endpackage

// File: rtl/cmplx_mult_pipe_if.sv
// Streaming handshake bundle for cmplx_mult_pipe: operand input side and result output side.
// The slave modport is the multiplier's view; master is the surrounding datapath's view.
interface cmplx_mult_pipe_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int OUTPUT_WIDTH = DATA_WIDTH
) ();

    logic                           in_valid;
    logic                           in_ready;
    logic                           in_conj;
    logic signed [DATA_WIDTH-1:0]   real_a;
    logic signed [DATA_WIDTH-1:0]   imag_a;
    logic signed [DATA_WIDTH-1:0]   real_b;
    logic signed [DATA_WIDTH-1:0]   imag_b;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [OUTPUT_WIDTH-1:0] real_result;
    logic signed [OUTPUT_WIDTH-1:0] imag_result;
    logic                           out_sat;

    modport slave (
        input  in_valid, in_conj, real_a, imag_a, real_b, imag_b, out_ready,
        output in_ready, out_valid, real_result, imag_result, out_sat
    );

    modport master (
        output in_valid, in_conj, real_a, imag_a, real_b, imag_b, out_ready,
        input  in_ready, out_valid, real_result, imag_result, out_sat
    );

endinterface

// File: rtl/cmplx_round_sat.sv
// Combinational round-half-up, arithmetic shift and clip of one component sum.
// CMPLX_MULT_SAT_EN selects clipping; without it the shifted value wraps and o_clip is 0.
module cmplx_round_sat
    import cmplx_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_WIDTH_F = 14,
    parameter int OUTPUT_WIDTH = DATA_WIDTH
) (
    input  logic signed [2*DATA_WIDTH:0]   i_sum,
    output logic signed [OUTPUT_WIDTH-1:0] o_val,
    output logic                           o_clip
);

    // One guard bit above the sum keeps the rounding add from overflowing.
    localparam int SW = 2 * DATA_WIDTH + 2;

    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] w_rnd;
    logic signed [SW-1:0] w_shr;

    always_comb begin
        w_ext = {i_sum[2*DATA_WIDTH], i_sum};
        w_rnd = w_ext + SW'(rnd_offset(DATA_WIDTH_F));
        w_shr = w_rnd >>> DATA_WIDTH_F;
    end

`ifdef CMPLX_MULT_SAT_EN
    logic w_fits;

    // The value fits when every bit from the output sign bit upward agrees.
    always_comb begin
        w_fits = (&w_shr[SW-1:OUTPUT_WIDTH-1]) || !(|w_shr[SW-1:OUTPUT_WIDTH-1]);
        o_clip = !w_fits;
        if (w_fits) begin
            o_val = w_shr[OUTPUT_WIDTH-1:0];
        end else if (w_shr[SW-1]) begin
            o_val = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        end else begin
            o_val = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        o_val  = OUTPUT_WIDTH'(w_shr);
        o_clip = 1'b0;
    end
`endif

endmodule

// File: rtl/cmplx_mult_pipe.sv
// Three-stage pipelined complex multiplier A*B or A*conj(B) with valid/ready backpressure.
// Define CMPLX_MULT_SAT_EN for saturating output with out_sat/ovf_sticky; otherwise results wrap.
module cmplx_mult_pipe
    import cmplx_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_WIDTH_F = 14,
    parameter int OUTPUT_WIDTH = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_ovf,
    output logic                 ovf_sticky,
    cmplx_mult_pipe_if.slave     bus
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = 2 * DATA_WIDTH + 1;

    logic w_advance;

    logic                         r_vld_p0;
    logic                         r_conj_p0;
    logic signed [DATA_WIDTH-1:0] r_ar_p0;
    logic signed [DATA_WIDTH-1:0] r_ai_p0;
    logic signed [DATA_WIDTH-1:0] r_br_p0;
    logic signed [DATA_WIDTH-1:0] r_bi_p0;

    logic                 r_vld_p1;
    logic                 r_conj_p1;
    logic signed [PW-1:0] r_rr_p1;
    logic signed [PW-1:0] r_ii_p1;
    logic signed [PW-1:0] r_ri_p1;
    logic signed [PW-1:0] r_ir_p1;

    logic signed [SW-1:0]           w_sum_re;
    logic signed [SW-1:0]           w_sum_im;
    logic signed [OUTPUT_WIDTH-1:0] w_re;
    logic signed [OUTPUT_WIDTH-1:0] w_im;
    logic                           w_clip_re;
    logic                           w_clip_im;

    logic                           r_vld_p2;
    logic signed [OUTPUT_WIDTH-1:0] r_re_p2;
    logic signed [OUTPUT_WIDTH-1:0] r_im_p2;
    logic                           r_sat_p2;

    // The whole pipe moves together; in_ready depends only on output-side state.
    assign w_advance    = !r_vld_p2 || bus.out_ready;
    assign bus.in_ready = w_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_advance) begin
            r_vld_p0 <= bus.in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // ---- stage p0: operand capture
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_conj_p0 <= bus.in_conj;
            r_ar_p0   <= bus.real_a;
            r_ai_p0   <= bus.imag_a;
            r_br_p0   <= bus.real_b;
            r_bi_p0   <= bus.imag_b;
        end
    end

    // ---- stage p1: four partial products
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_conj_p1 <= r_conj_p0;
            r_rr_p1   <= r_ar_p0 * r_br_p0;
            r_ii_p1   <= r_ai_p0 * r_bi_p0;
            r_ri_p1   <= r_ar_p0 * r_bi_p0;
            r_ir_p1   <= r_ai_p0 * r_br_p0;
        end
    end

    // Conjugation flips signs at the sum so a most-negative imag_b never needs negating.
    always_comb begin
        if (r_conj_p1) begin
            w_sum_re = SW'(r_rr_p1) + SW'(r_ii_p1);
            w_sum_im = SW'(r_ir_p1) - SW'(r_ri_p1);
        end else begin
            w_sum_re = SW'(r_rr_p1) - SW'(r_ii_p1);
            w_sum_im = SW'(r_ri_p1) + SW'(r_ir_p1);
        end
    end

    cmplx_round_sat #(
        .DATA_WIDTH   (DATA_WIDTH),
        .DATA_WIDTH_F (DATA_WIDTH_F),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_rs_re (
        .i_sum  (w_sum_re),
        .o_val  (w_re),
        .o_clip (w_clip_re)
    );

    cmplx_round_sat #(
        .DATA_WIDTH   (DATA_WIDTH),
        .DATA_WIDTH_F (DATA_WIDTH_F),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_rs_im (
        .i_sum  (w_sum_im),
        .o_val  (w_im),
        .o_clip (w_clip_im)
    );

    // ---- stage p2: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re_p2  <= '0;
            r_im_p2  <= '0;
            r_sat_p2 <= 1'b0;
        end else if (w_advance) begin
            r_re_p2  <= w_re;
            r_im_p2  <= w_im;
            r_sat_p2 <= r_vld_p1 && (w_clip_re || w_clip_im);
        end
    end

    // A new clip takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (w_advance && r_vld_p1 && (w_clip_re || w_clip_im)) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign bus.out_valid   = r_vld_p2;
    assign bus.real_result = r_re_p2;
    assign bus.imag_result = r_im_p2;
    assign bus.out_sat     = r_sat_p2;

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Directed bench for cmplx_mult_pipe at the default Q1.14 16-bit configuration.
// Expected values are hand-computed; clip-dependent ones follow CMPLX_MULT_SAT_EN.
module tb_cmplx_mult_pipe;
    import cmplx_pkg::*;

    logic clk;
    logic rst_n;
    logic clr_ovf;
    logic ovf_sticky;
    int   n_chk;
    int   n_err;

    cmplx_mult_pipe_if #(.DATA_WIDTH(16), .OUTPUT_WIDTH(16)) bus ();

    cmplx_mult_pipe #(
        .DATA_WIDTH   (16),
        .DATA_WIDTH_F (14),
        .OUTPUT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_ovf    (clr_ovf),
        .ovf_sticky (ovf_sticky),
        .bus        (bus)
    );

`ifdef CMPLX_MULT_SAT_EN
    localparam logic [15:0] SAT_RE  = 16'h7FFF;
    localparam logic [15:0] SAT_IM2 = 16'h7FFF;
    localparam logic        SAT_F   = 1'b1;
`else
    localparam logic [15:0] SAT_RE  = 16'h0000;
    localparam logic [15:0] SAT_IM2 = 16'h8000;
    localparam logic        SAT_F   = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input cmplx_t a, input cmplx_t b, input logic conj);
        bus.real_a  = a.re;
        bus.imag_a  = a.im;
        bus.real_b  = b.re;
        bus.imag_b  = b.im;
        bus.in_conj = conj;
    endtask

    // One sample into an idle pipe with out_ready held high; checks latency and result.
    task automatic run_one(input string tag, input cmplx_t a, input cmplx_t b, input logic conj,
                           input logic [15:0] er, input logic [15:0] ei, input logic esat);
        int cyc;
        @(negedge clk);
        drive(a, b, conj);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 16'(cyc), 16'(PIPE_LATENCY));
        chk({tag, "_re"}, bus.real_result, er);
        chk({tag, "_im"}, bus.imag_result, ei);
        chk({tag, "_sat"}, 16'(bus.out_sat), 16'(esat));
    endtask

    cmplx_t bp_a [8];
    cmplx_t bp_b [8];
    logic   bp_c [8];
    logic [15:0] bp_er [8];
    logic [15:0] bp_ei [8];

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        clr_ovf       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive('0, '0, 1'b0);

        #1;
        chk("rst_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_ready", 16'(bus.in_ready), 16'h1);
        chk("rst_re", bus.real_result, 16'h0);
        chk("rst_im", bus.imag_result, 16'h0);
        chk("rst_sat", 16'(bus.out_sat), 16'h0);
        chk("rst_ovf", 16'(ovf_sticky), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_one("basic", '{16'sh2000, 16'sh2000}, '{16'sh2000, 16'sh0000}, 1'b0, 16'h1000, 16'h1000, 1'b0);
        run_one("conj",  '{16'sh2000, 16'sh2000}, '{16'sh0000, 16'sh2000}, 1'b1, 16'h1000, 16'hF000, 1'b0);
        run_one("rnd_up", '{16'sh0001, 16'sh0000}, '{16'sh2000, 16'sh0000}, 1'b0, 16'h0001, 16'h0000, 1'b0);
        run_one("rnd_neg", '{-16'sh0001, 16'sh0000}, '{16'sh2000, 16'sh0000}, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("ovf_before", 16'(ovf_sticky), 16'h0);

        run_one("sat", '{-16'sh8000, 16'sh0000}, '{-16'sh8000, 16'sh0000}, 1'b0, SAT_RE, 16'h0000, SAT_F);
        chk("ovf_set", 16'(ovf_sticky), 16'(SAT_F));
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_hold", 16'(ovf_sticky), 16'(SAT_F));
        chk("sat_cleared_out", 16'(bus.out_sat), 16'h0);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", 16'(ovf_sticky), 16'h0);

        // Most-negative imag_b under conjugation: imag = -(1.0 * -2.0) = +2.0
        run_one("conj_minb", '{16'sh4000, 16'sh0000}, '{16'sh0000, -16'sh8000}, 1'b1, 16'h0000, SAT_IM2, SAT_F);
        run_one("after_sat", '{16'sh4000, 16'sh0000}, '{16'sh1234, -16'sh0100}, 1'b0, 16'h1234, 16'hFF00, 1'b0);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;

        // Backpressure: b = j, conj on odd samples gives (-ai, ar) or (ai, -ar).
        for (int i = 0; i < 8; i++) begin
            bp_a[i].re = 16'(16'sh0100 * (i + 1));
            bp_a[i].im = 16'(-16'sh0080 * (i + 1));
            bp_b[i]    = '{16'sh0000, 16'sh4000};
            bp_c[i]    = i[0];
            bp_er[i]   = i[0] ? bp_a[i].im : 16'(-bp_a[i].im);
            bp_ei[i]   = i[0] ? 16'(-bp_a[i].re) : bp_a[i].re;
        end
        bus.out_ready = 1'b0;
        fork
            begin : driver
                int idx;
                logic acc;
                idx = 0;
                while (idx < 8) begin
                    @(negedge clk);
                    drive(bp_a[idx], bp_b[idx], bp_c[idx]);
                    bus.in_valid = 1'b1;
                    acc = bus.in_ready;
                    @(posedge clk);
                    if (acc) idx++;
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin : receiver
                int k;
                int cyc;
                logic held;
                logic [15:0] h_re;
                logic [15:0] h_im;
                k    = 0;
                cyc  = 0;
                held = 1'b0;
                h_re = '0;
                h_im = '0;
                while (k < 8 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    if (held) begin
                        chk("bp_hold_valid", 16'(bus.out_valid), 16'h1);
                        chk("bp_hold_re", bus.real_result, h_re);
                        chk("bp_hold_im", bus.imag_result, h_im);
                    end
                    held = 1'b0;
                    if (bus.out_valid) begin
                        if (bus.out_ready) begin
                            chk($sformatf("bp_re%0d", k), bus.real_result, bp_er[k]);
                            chk($sformatf("bp_im%0d", k), bus.imag_result, bp_ei[k]);
                            k++;
                        end else begin
                            held = 1'b1;
                            h_re = bus.real_result;
                            h_im = bus.imag_result;
                        end
                    end
                    @(posedge clk);
                    #1;
                    bus.out_ready = ~bus.out_ready;
                end
                chk("bp_count", 16'(k), 16'd8);
            end
        join
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_dup", 16'(bus.out_valid), 16'h0);

        // Async reset with three samples in flight
        @(negedge clk);
        drive('{16'sh1000, 16'sh0000}, '{16'sh4000, 16'sh0000}, 1'b0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive('{16'sh2000, 16'sh0000}, '{16'sh4000, 16'sh0000}, 1'b0);
        @(negedge clk);
        drive('{16'sh3000, 16'sh0000}, '{16'sh4000, 16'sh0000}, 1'b0);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        chk("mid_pre_valid", 16'(bus.out_valid), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(bus.out_valid), 16'h0);
        chk("mid_rst_re", bus.real_result, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) seen++;
            end
            chk("mid_no_stale", 16'(seen), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
